change_dispense_engine: RTL

Parametrised successor to the single-item change calculator in the ticket/vending datapath.
- Latches a multi-line order, computes the total with one multiply-accumulate per cycle, and selects cost: either the order total or a flat ticket price.
- Compares cost against the paid amount, then breaks the change into coins from largest to smallest denomination.
- Each coin is handed to the coin dispenser over a valid/ready handshake.
- Sits between the sale FSM, which issues start/abort, and the coin-output driver.

---
 rtl/change_pkg.sv | 26 ++
 rtl/change_coin_picker.sv | 29 ++
 rtl/change_dispense_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_pkg
// Description : Shared state encoding and coin denomination table for the
//               change dispense engine.
// Revision    : 1.0 - initial release
// ============================================================================
package change_pkg;

    localparam int N_DENOM = 6;

    // Must stay sorted largest first; the coin picker relies on it.
    localparam logic [31:0] DENOM [N_DENOM] = '{
        32'd100, 32'd50, 32'd20, 32'd10, 32'd5, 32'd1
    };

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SUM      = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPENSE = 3'd3,
        S_DONE     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/change_coin_picker.sv
`default_nettype none
// ============================================================================
// Module      : change_coin_picker
// Description : Picks the largest denomination not exceeding the remaining
//               change (lowest index into the descending DENOM table).
// Revision    : 1.0 - initial release
// ============================================================================
module change_coin_picker
    import change_pkg::*;
#(
    parameter int W     = 32,
    parameter int IDX_W = $clog2(N_DENOM)
) (
    input  logic [W-1:0]     remaining,
    output logic [IDX_W-1:0] coin_idx
);

    // Scan smallest to largest so the last match is the largest fitting coin.
    always_comb begin
        coin_idx = '0;
        for (int k = N_DENOM - 1; k >= 0; k--) begin
            if (W'(DENOM[k]) <= remaining) begin
                coin_idx = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispense_engine.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_engine
// Description : Sums a latched multi-line order, checks payment and hands the
//               change out coin by coin over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispense_engine
    import change_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_ITEMS = 4,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = $clog2(N_DENOM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ticket_mode,
    input  logic [W-1:0]             ticket_price,
    input  logic [W-1:0]             real_pay,
    input  logic [N_ITEMS*W-1:0]     price,
    input  logic [N_ITEMS*CNT_W-1:0] amount,
    output logic                     busy,
    output logic                     done,
    output logic [W-1:0]             total,
    output logic [W-1:0]             change,
    output logic                     insufficient,
    output logic                     overflow,
    output logic                     coin_valid,
    output logic [IDX_W-1:0]         coin_idx,
    input  logic                     coin_ready
);

    localparam int c_line_w = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_ticket_mode;
    logic [W-1:0]               r_ticket_price;
    logic [W-1:0]               r_real_pay;
    logic [N_ITEMS*W-1:0]       r_price;
    logic [N_ITEMS*CNT_W-1:0]   r_amount;
    logic [c_line_w-1:0]        r_line;
    logic [W-1:0]               r_total;
    logic [W-1:0]               r_change;
    logic [W-1:0]               r_remaining;
    logic                       r_insufficient;
    logic                       r_overflow;

    logic [W-1:0]               w_price_line  [N_ITEMS];
    logic [CNT_W-1:0]           w_amount_line [N_ITEMS];
    logic [W+CNT_W-1:0]         w_product;
    logic [W:0]                 w_sum;
    logic [W-1:0]               w_cost;
    logic [W-1:0]               w_change_calc;
    logic [W-1:0]               w_rem_next;
    logic [IDX_W-1:0]           w_pick;
    logic                       w_last_line;
    logic                       w_short;
    logic                       w_handshake;

    generate
        for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_lines
            assign w_price_line[gi]  = r_price[gi*W +: W];
            assign w_amount_line[gi] = r_amount[gi*CNT_W +: CNT_W];
        end
    endgenerate

    change_coin_picker #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_picker (
        .remaining (r_remaining),
        .coin_idx  (w_pick)
    );

    assign w_product     = {{CNT_W{1'b0}}, w_price_line[r_line]}
                         * {{W{1'b0}}, w_amount_line[r_line]};
    assign w_sum         = {1'b0, r_total} + {1'b0, w_product[W-1:0]};
    assign w_last_line   = (r_line == c_line_w'(N_ITEMS - 1));
    assign w_cost        = r_ticket_mode ? r_ticket_price : r_total;
    assign w_short       = r_overflow || (r_real_pay < w_cost);
    assign w_change_calc = r_real_pay - w_cost;
    assign w_handshake   = coin_valid && coin_ready;
    assign w_rem_next    = r_remaining - W'(DENOM[w_pick]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_next = S_SUM;
            end
            S_SUM: begin
                if (abort)            w_state_next = S_IDLE;
                else if (w_last_line) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (abort)                   w_state_next = S_IDLE;
                else if (w_short)            w_state_next = S_DONE;
                else if (w_change_calc == 0) w_state_next = S_DONE;
                else                         w_state_next = S_DISPENSE;
            end
            S_DISPENSE: begin
                if (abort)                              w_state_next = S_IDLE;
                else if (w_handshake && w_rem_next == 0) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath; results of an aborted transaction are left as they stood.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ticket_mode  <= 1'b0;
            r_ticket_price <= '0;
            r_real_pay     <= '0;
            r_price        <= '0;
            r_amount       <= '0;
            r_line         <= '0;
            r_total        <= '0;
            r_change       <= '0;
            r_remaining    <= '0;
            r_insufficient <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_ticket_mode  <= ticket_mode;
                        r_ticket_price <= ticket_price;
                        r_real_pay     <= real_pay;
                        r_price        <= price;
                        r_amount       <= amount;
                        r_line         <= '0;
                        r_total        <= '0;
                        r_change       <= '0;
                        r_insufficient <= 1'b0;
                        r_overflow     <= 1'b0;
                    end
                end
                S_SUM: begin
                    if (!abort) begin
                        r_total    <= w_sum[W-1:0];
                        r_overflow <= r_overflow | w_sum[W] | (|w_product[W+CNT_W-1:W]);
                        r_line     <= r_line + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!abort) begin
                        if (w_short) begin
                            r_insufficient <= 1'b1;
                            r_change       <= '0;
                        end else begin
                            r_change    <= w_change_calc;
                            r_remaining <= w_change_calc;
                        end
                    end
                end
                S_DISPENSE: begin
                    // A coin accepted alongside abort has physically left.
                    if (w_handshake) r_remaining <= w_rem_next;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign coin_valid   = (r_state == S_DISPENSE);
    assign coin_idx     = coin_valid ? w_pick : '0;
    assign total        = r_total;
    assign change       = r_change;
    assign insufficient = r_insufficient;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire
